mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 133 +++++++++++++
 tb/tb_mem_responder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Byte-wide RAM plus TX/RX byte FIFOs behind a single-cycle bus, with a sticky halt flag.
// Define MEM_RESPONDER_RX_EN to build the RX FIFO; without it rx_ready is tied low.
module mem_responder #(
  parameter int ADDR_WIDTH = 17,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  input  logic [31:0] mem_addr,
  input  logic [7:0]  mem_write,
  input  logic        r_nw_in,
  output logic [7:0]  mem_read,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        halt_out
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [31:0] IO_DATA = 32'h0003_0000;
  localparam logic [31:0] IO_CTRL = 32'h0003_0004;

  logic ram_sel, data_sel, ctrl_sel, bus_rd, bus_wr;
  logic [ADDR_WIDTH-1:0] ram_idx;
  logic [7:0] ram [2**ADDR_WIDTH];
  logic [7:0] rd_next;

  assign ram_sel  = mem_addr < IO_DATA;
  assign data_sel = mem_addr == IO_DATA;
  assign ctrl_sel = mem_addr == IO_CTRL;
  assign bus_rd   = rdy_in & r_nw_in;
  assign bus_wr   = rdy_in & ~r_nw_in;
  assign ram_idx  = mem_addr[ADDR_WIDTH-1:0];

  always_ff @(posedge clk_in) begin
    if (bus_wr && ram_sel) ram[ram_idx] <= mem_write;
  end

  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [PW-1:0] tx_wr_ptr, tx_rd_ptr;
  logic [CW-1:0] tx_count;
  logic          tx_full, tx_push, tx_pop;

  // A write while full is still accepted when the stream pops in the same cycle.
  assign tx_full        = tx_count == DEPTH_C;
  assign tx_valid       = tx_count != '0;
  assign tx_data        = tx_mem[tx_rd_ptr];
  assign io_buffer_full = tx_full;
  assign tx_pop         = tx_valid & tx_ready;
  assign tx_push        = bus_wr & data_sel & (~tx_full | tx_pop);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + PW'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PW'(1);
      if (tx_push && !tx_pop)      tx_count <= tx_count + CW'(1);
      else if (!tx_push && tx_pop) tx_count <= tx_count - CW'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= mem_write;
  end

  logic       rx_nonempty;
  logic [7:0] rx_head;

`ifdef MEM_RESPONDER_RX_EN
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [PW-1:0] rx_wr_ptr, rx_rd_ptr;
  logic [CW-1:0] rx_count;
  logic          rx_push, rx_pop;

  assign rx_ready    = rx_count != DEPTH_C;
  assign rx_nonempty = rx_count != '0;
  assign rx_head     = rx_mem[rx_rd_ptr];
  assign rx_push     = rx_valid & rx_ready;
  assign rx_pop      = bus_rd & data_sel & rx_nonempty;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + PW'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PW'(1);
      if (rx_push && !rx_pop)      rx_count <= rx_count + CW'(1);
      else if (!rx_push && rx_pop) rx_count <= rx_count - CW'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= rx_data;
  end
`else
  logic unused_rx;
  assign unused_rx   = ^{rx_data, rx_valid};
  assign rx_ready    = 1'b0;
  assign rx_nonempty = 1'b0;
  assign rx_head     = 8'h00;
`endif

  always_comb begin
    rd_next = 8'h00;
    if (ram_sel)       rd_next = ram[ram_idx];
    else if (data_sel) rd_next = rx_nonempty ? rx_head : 8'h00;
    else if (ctrl_sel) rd_next = {6'b0, rx_nonempty, tx_full};
  end

  // mem_read only changes on an accepted read; writes and stalled cycles hold it.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      mem_read <= 8'h00;
      halt_out <= 1'b0;
    end else begin
      if (bus_rd) mem_read <= rd_next;
      if (bus_wr && ctrl_sel) halt_out <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: queue-based reference model, decoupled monitor.
module tb_mem_responder;

  localparam int AW    = 17;
  localparam int DEPTH = 8;
`ifdef MEM_RESPONDER_RX_EN
  localparam bit RX_EN = 1'b1;
`else
  localparam bit RX_EN = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b1;
  logic        rdy_in = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [7:0]  mem_write = '0;
  logic        r_nw_in = 1'b1;
  logic [7:0]  mem_read;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        halt_out;

  mem_responder #(.ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .mem_addr(mem_addr),
    .mem_write(mem_write), .r_nw_in(r_nw_in), .mem_read(mem_read),
    .io_buffer_full(io_buffer_full), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .halt_out(halt_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int         due;
    logic [7:0] rd;
    logic       halt;
    logic       full;
    logic       txv;
    logic       rxr;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] exp_tx[$];
  logic [7:0] m_tx[$];
  logic [7:0] m_rx[$];
  logic [7:0] m_ram [int];
  logic [7:0] m_rd = 8'h00;
  logic       m_halt = 1'b0;
  int         cyc = 0;
  int         vectors = 0;
  int         miscompares = 0;
  exp_t       mon_e;
  logic [7:0] mon_b;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [7:0] got, input logic [7:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s: got %02h, required %02h at t=%0t", name, got, want, $time);
    end
  endtask

  task automatic setIdle();
    rdy_in = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0;
    mem_addr = '0; mem_write = '0; r_nw_in = 1'b1; rx_data = '0;
  endtask

  // Drives one cycle of inputs and advances the model to the state after the next edge.
  task automatic applyStimulus(input logic [31:0] addr, input logic [7:0] wd, input logic rnw,
                               input logic rdy, input logic txr, input logic rxv,
                               input logic [7:0] rxd);
    logic [7:0] rv;
    logic       tx_pop, rx_push, push_tx;
    int         idx;
    exp_t       e;
    @(posedge clk_in); #2;
    mem_addr = addr; mem_write = wd; r_nw_in = rnw; rdy_in = rdy;
    tx_ready = txr; rx_valid = rxv; rx_data = rxd;
    tx_pop  = (m_tx.size() != 0) && txr;
    rx_push = RX_EN && rxv && (m_rx.size() < DEPTH);
    push_tx = 1'b0;
    idx = int'(addr % (32'd1 << AW));
    if (rdy && rnw) begin
      rv = 8'h00;
      if (addr < 32'h30000) rv = m_ram[idx];
      else if (addr == 32'h30000) begin
        if (m_rx.size() != 0) rv = m_rx.pop_front();
      end else if (addr == 32'h30004) rv = {6'b0, m_rx.size() != 0, m_tx.size() == DEPTH};
      m_rd = rv;
    end
    if (rdy && !rnw) begin
      if (addr < 32'h30000) m_ram[idx] = wd;
      else if (addr == 32'h30000) push_tx = (m_tx.size() < DEPTH) || tx_pop;
      else if (addr == 32'h30004) m_halt = 1'b1;
    end
    if (tx_pop)  exp_tx.push_back(m_tx.pop_front());
    if (push_tx) m_tx.push_back(wd);
    if (rx_push) m_rx.push_back(rxd);
    e.due  = cyc + 1;
    e.rd   = m_rd;
    e.halt = m_halt;
    e.full = m_tx.size() == DEPTH;
    e.txv  = m_tx.size() != 0;
    e.rxr  = RX_EN && (m_rx.size() != DEPTH);
    exp_q.push_back(e);
  endtask

  task automatic pulseReset();
    @(posedge clk_in); #2;
    setIdle();
    @(negedge clk_in); #1;
    checkOutput("pre_reset_tx_valid", tx_valid, m_tx.size() != 0);
    rst_n_in = 1'b0;
    #1;
    checkOutput("reset_tx_valid", tx_valid, 8'h00);
    checkOutput("reset_halt", halt_out, 8'h00);
    checkOutput("reset_full", io_buffer_full, 8'h00);
    checkOutput("reset_rx_ready", rx_ready, RX_EN);
    checkOutput("reset_mem_read", mem_read, 8'h00);
    m_tx.delete(); m_rx.delete(); exp_tx.delete(); exp_q.delete();
    m_rd = 8'h00; m_halt = 1'b0;
    @(posedge clk_in); #2;
    rst_n_in = 1'b1;
  endtask

  // Monitor: stream handshakes and per-cycle bus/status expectations.
  always @(negedge clk_in) begin
    if (rst_n_in === 1'b1) begin
      if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
        if (exp_tx.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL tx_stream: got %02h, required no byte at t=%0t", tx_data, $time);
        end else begin
          mon_b = exp_tx.pop_front();
          checkOutput("tx_stream", tx_data, mon_b);
        end
      end
      if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
        mon_e = exp_q.pop_front();
        checkOutput("mem_read", mem_read, mon_e.rd);
        checkOutput("halt_out", halt_out, mon_e.halt);
        checkOutput("io_buffer_full", io_buffer_full, mon_e.full);
        checkOutput("tx_valid", tx_valid, mon_e.txv);
        checkOutput("rx_ready", rx_ready, mon_e.rxr);
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  logic [31:0] pool [8] = '{32'h0, 32'h1, 32'h7, 32'h10, 32'hFF, 32'h20010, 32'h1FFFF, 32'h2FFFF};
  logic [31:0] unmapped [4] = '{32'h30001, 32'h30003, 32'h30008, 32'hFFFF_FFFF};

  initial begin
    int sel;
    logic [31:0] a;
    setIdle();
    pulseReset();

    applyStimulus(32'h10, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    applyStimulus(32'h10, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);

    for (int i = 0; i < 9; i++)
      applyStimulus(32'h30000, 8'h41 + 8'(i), 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++)
      applyStimulus(32'h0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);

    for (int i = 0; i < 8; i++)
      applyStimulus(32'h30000, 8'h41 + 8'(i), 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    applyStimulus(32'h30000, 8'h50, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++)
      applyStimulus(32'h0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);

    applyStimulus(32'h0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h31);
    applyStimulus(32'h0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h32);
    applyStimulus(32'h30004, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++)
      applyStimulus(32'h30000, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);

    applyStimulus(32'h10, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    applyStimulus(32'h30000, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    applyStimulus(32'h10, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

    applyStimulus(32'h30004, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++)
      applyStimulus(32'h30000, 8'h60 + 8'(i), 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    applyStimulus(32'h0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    pulseReset();
    applyStimulus(32'h10, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    applyStimulus(32'h0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("ram_survives_reset", mem_read, 8'h5A);

    for (int i = 0; i < 8; i++)
      applyStimulus(pool[i], 8'($urandom), 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);

    for (int i = 0; i < 400; i++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 4)       a = pool[$urandom_range(0, 7)];
      else if (sel < 7)  a = 32'h30000;
      else if (sel == 7) a = 32'h30004;
      else               a = unmapped[$urandom_range(0, 3)];
      applyStimulus(a, 8'($urandom),
                    (a == 32'h30004) ? ($urandom_range(0, 15) != 0) : 1'($urandom),
                    $urandom_range(0, 9) < 8, 1'($urandom), 1'($urandom), 8'($urandom));
    end

    @(posedge clk_in); #2;
    setIdle();
    @(negedge clk_in);
    @(negedge clk_in); #1;
    vectors++;
    if (exp_q.size() != 0 || exp_tx.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_drain: got %0d/%0d pending, required 0/0",
               exp_q.size(), exp_tx.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
